// File: rtl/command_core_pkg.sv
// Shared definitions for the command-controlled core: instruction fields,
// opcode values and controller state encoding.
package command_core_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned OP_MSB  = 11;
  localparam int unsigned OP_LSB  = 8;
  localparam int unsigned ARG_MSB = 7;
  localparam int unsigned ARG_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_IN   = 4'h1;
  localparam logic [3:0] OP_OUT  = 4'h2;
  localparam logic [3:0] OP_LDA  = 4'h3;
  localparam logic [3:0] OP_LDB  = 4'h4;
  localparam logic [3:0] OP_STA  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  function automatic logic [3:0] instr_op(input logic [INSTR_W-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [7:0] instr_arg(input logic [INSTR_W-1:0] w);
    return w[ARG_MSB:ARG_LSB];
  endfunction

endpackage

// File: rtl/command_core_alu.sv
// Arithmetic/logic datapath: ADD/SUB/AND on regA,regB and SHL on regB.
// carry_o is carry-out, borrow, or the bit shifted out depending on the opcode.
module command_core_alu
  import command_core_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [3:0]            op_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o,
  output logic                  zero_o
);

  logic [DATA_WIDTH:0] wide;

  // The extra top bit holds carry, borrow (a<b) or the old MSB of b for SHL.
  always_comb begin
    wide = '0;
    case (op_i)
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_SHL:  wide = {b_i, 1'b0};
      default: wide = {1'b0, a_i};
    endcase
  end

  assign result_o = wide[DATA_WIDTH-1:0];
  assign carry_o  = wide[DATA_WIDTH];
  assign zero_o   = (result_o == '0);

endmodule

// File: rtl/command_controlled_core.sv
// Tiny accumulator processor: loads a program through a write port, then
// executes one instruction per cycle with stalling port IN/OUT accesses.
module command_controlled_core
  import command_core_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int GPR_COUNT     = 4,
  parameter int PROG_DEPTH    = 16,
  parameter int PORT_ID_WIDTH = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     prog_we,
  input  logic [7:0]               prog_addr,
  input  logic [11:0]              prog_data,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     port_ready,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [PORT_ID_WIDTH-1:0] port_id,
  output logic                     port_read,
  output logic                     port_write,
  output logic [7:0]               pc,
  output logic                     busy,
  output logic                     halted,
  output logic                     error,
  output logic                     flag_z,
  output logic                     flag_c
);

  localparam int unsigned PA_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int unsigned GA_W = (GPR_COUNT > 1) ? $clog2(GPR_COUNT) : 1;

  state_e                 state_q, state_d;
  logic [7:0]             pc_q, pc_d;
  logic [DATA_WIDTH-1:0]  rega_q, rega_d;
  logic [DATA_WIDTH-1:0]  regb_q, regb_d;
  logic [DATA_WIDTH-1:0]  gpr_q [GPR_COUNT];
  logic [DATA_WIDTH-1:0]  gpr_d [GPR_COUNT];
  logic                   fz_q, fz_d;
  logic                   fc_q, fc_d;
  logic                   err_q, err_d;

  logic [INSTR_W-1:0]     mem_q [PROG_DEPTH];
  logic [INSTR_W-1:0]     instr;
  logic [3:0]             op;
  logic [7:0]             arg;
  logic                   run;
  logic                   r_bad;
  logic                   t_bad;
  logic                   fault;
  logic [7:0]             pc_inc;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_c;
  logic                   alu_z;

  // Program memory is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (prog_we && (state_q != ST_RUN) && (32'(prog_addr) < 32'(PROG_DEPTH)))
      mem_q[prog_addr[PA_W-1:0]] <= prog_data;
  end

  assign instr  = mem_q[pc_q[PA_W-1:0]];
  assign op     = instr_op(instr);
  assign arg    = instr_arg(instr);
  assign run    = (state_q == ST_RUN);
  assign r_bad  = (32'(arg) >= 32'(GPR_COUNT));
  assign t_bad  = (32'(arg) >= 32'(PROG_DEPTH));
  assign pc_inc = (32'(pc_q) == 32'(PROG_DEPTH - 1)) ? '0 : pc_q + 8'd1;

  command_core_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .a_i      (rega_q),
    .b_i      (regb_q),
    .op_i     (op),
    .result_o (alu_res),
    .carry_o  (alu_c),
    .zero_o   (alu_z)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    gpr_d   = gpr_q;
    fz_d    = fz_q;
    fc_d    = fc_q;
    err_d   = err_q;
    fault   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          err_d   = 1'b0;
          fz_d    = 1'b0;
          fc_d    = 1'b0;
        end
      end
      ST_RUN: begin
        case (op)
          OP_NOP: pc_d = pc_inc;
          OP_IN: begin
            if (port_ready) begin
              rega_d = data_in;
              pc_d   = pc_inc;
            end
          end
          OP_OUT: if (port_ready) pc_d = pc_inc;
          OP_LDA, OP_LDB, OP_STA: begin
            if (r_bad) begin
              fault = 1'b1;
            end else begin
              if (op == OP_LDA) rega_d = gpr_q[arg[GA_W-1:0]];
              if (op == OP_LDB) regb_d = gpr_q[arg[GA_W-1:0]];
              if (op == OP_STA) gpr_d[arg[GA_W-1:0]] = rega_q;
              pc_d = pc_inc;
            end
          end
          OP_ADD, OP_SUB: begin
            rega_d = alu_res;
            fc_d   = alu_c;
            fz_d   = alu_z;
            pc_d   = pc_inc;
          end
          OP_AND: begin
            rega_d = alu_res;
            fz_d   = alu_z;
            pc_d   = pc_inc;
          end
          OP_SHL: begin
            regb_d = alu_res;
            fc_d   = alu_c;
            fz_d   = alu_z;
            pc_d   = pc_inc;
          end
          OP_JMP, OP_JZ, OP_JC: begin
            // Target range only matters when the branch is actually taken.
            if ((op == OP_JMP) || (op == OP_JZ && fz_q) || (op == OP_JC && fc_q)) begin
              if (t_bad) fault = 1'b1;
              else       pc_d  = arg;
            end else begin
              pc_d = pc_inc;
            end
          end
          OP_HALT: state_d = ST_HALTED;
          default: fault = 1'b1;
        endcase
        if (fault) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      gpr_q   <= '{default: '0};
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      gpr_q   <= gpr_d;
      fz_q    <= fz_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

  assign port_read  = run && (op == OP_IN);
  assign port_write = run && (op == OP_OUT);
  assign port_id    = (port_read || port_write) ? arg[PORT_ID_WIDTH-1:0] : '0;
  assign data_out   = rega_q;
  assign pc         = pc_q;
  assign busy       = run;
  assign halted     = (state_q == ST_HALTED);
  assign error      = err_q;
  assign flag_z     = fz_q;
  assign flag_c     = fc_q;

endmodule

// File: tb/tb_command_controlled_core.sv
// Directed bench for command_controlled_core: single-op vector table plus
// hand sequences for stalls, branches, faults, wrap-around and reset.
module tb_command_controlled_core;

  localparam logic [3:0] T_NOP = 4'h0, T_IN  = 4'h1, T_OUT = 4'h2, T_LDA = 4'h3;
  localparam logic [3:0] T_LDB = 4'h4, T_STA = 4'h5, T_ADD = 4'h6, T_SUB = 4'h7;
  localparam logic [3:0] T_AND = 4'h8, T_SHL = 4'h9, T_JMP = 4'hA, T_JZ  = 4'hB;
  localparam logic [3:0] T_JC  = 4'hC, T_HLT = 4'hD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic [3:0]  data_in = '0;
  logic        port_ready = 1'b1;
  logic [3:0]  data_out;
  logic [2:0]  port_id;
  logic        port_read, port_write;
  logic [7:0]  pc;
  logic        busy, halted, error, flag_z, flag_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] pbuf [16];
  logic [3:0]  in_vals [4];
  int          in_idx, out_cnt, both_cnt, cyc, rd_cnt;
  logic [3:0]  last_out;
  logic [2:0]  last_pid;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_out;
    logic       exp_z;
    logic       exp_c;
  } vec_t;
  vec_t vecs [10];

  command_controlled_core #(
    .DATA_WIDTH    (4),
    .GPR_COUNT     (4),
    .PROG_DEPTH    (16),
    .PORT_ID_WIDTH (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .data_in    (data_in),
    .port_ready (port_ready),
    .data_out   (data_out),
    .port_id    (port_id),
    .port_read  (port_read),
    .port_write (port_write),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .error      (error),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] enc(input logic [3:0] op, input logic [7:0] arg);
    return {op, arg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [11:0] data);
    @(negedge clock);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = data;
    @(negedge clock);
    prog_we   = 1'b0;
  endtask

  task automatic load_prog(input int n);
    for (int i = 0; i < n; i++) write_word(8'(i), pbuf[i]);
  endtask

  // Starts the loaded program and runs until halted or the budget expires.
  task automatic run_prog(input int budget);
    in_idx = 0; out_cnt = 0; both_cnt = 0; cyc = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (!halted && cyc < budget) begin
      if (port_read && in_idx < 4) begin
        data_in = in_vals[in_idx];
        in_idx++;
      end
      if (port_write) begin
        last_out = data_out;
        last_pid = port_id;
        out_cnt++;
      end
      if (port_read && port_write) both_cnt++;
      @(negedge clock);
      cyc++;
    end
    check("run_halts", 32'(halted), 32'd1);
    check("strobe_excl", 32'(both_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{T_ADD, 4'd5,  4'd9,  4'd14, 1'b0, 1'b0};
    vecs[1] = '{T_ADD, 4'd9,  4'd9,  4'd2,  1'b0, 1'b1};
    vecs[2] = '{T_ADD, 4'd8,  4'd8,  4'd0,  1'b1, 1'b1};
    vecs[3] = '{T_SUB, 4'd9,  4'd4,  4'd5,  1'b0, 1'b0};
    vecs[4] = '{T_SUB, 4'd3,  4'd3,  4'd0,  1'b1, 1'b0};
    vecs[5] = '{T_SUB, 4'd2,  4'd5,  4'd13, 1'b0, 1'b1};
    vecs[6] = '{T_AND, 4'd12, 4'd10, 4'd8,  1'b0, 1'b0};
    vecs[7] = '{T_AND, 4'd5,  4'd10, 4'd0,  1'b1, 1'b0};
    vecs[8] = '{T_SHL, 4'd3,  4'd9,  4'd3,  1'b0, 1'b1};
    vecs[9] = '{T_SHL, 4'd7,  4'd8,  4'd7,  1'b1, 1'b1};

    // Reset state
    #12;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_strobes", {30'd0, port_read, port_write}, 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    @(negedge clock); reset = 1'b1;

    // Adder program; the alias write at address 16 must not clobber address 0
    pbuf[0] = enc(T_IN, 8'd1);  pbuf[1] = enc(T_STA, 8'd0); pbuf[2] = enc(T_IN, 8'd3);
    pbuf[3] = enc(T_LDB, 8'd0); pbuf[4] = enc(T_ADD, 8'd0); pbuf[5] = enc(T_OUT, 8'd2);
    pbuf[6] = enc(T_HLT, 8'd0);
    load_prog(7);
    write_word(8'h10, enc(T_HLT, 8'd0));
    in_vals[0] = 4'd5; in_vals[1] = 4'd9;
    run_prog(30);
    check("add_cycles", 32'(cyc), 32'd7);
    check("add_pid", 32'(last_pid), 32'd2);
    check("add_out", 32'(last_out), 32'd14);
    check("add_c", 32'(flag_c), 32'd0);
    check("add_pc", 32'(pc), 32'd6);
    in_vals[0] = 4'd9; in_vals[1] = 4'd9;
    run_prog(30);
    check("add2_out", 32'(last_out), 32'd2);
    check("add2_c", 32'(flag_c), 32'd1);

    // Table of single-operation vectors
    for (int i = 0; i < 10; i++) begin
      pbuf[0] = enc(T_IN, 8'd0);  pbuf[1] = enc(T_STA, 8'd0); pbuf[2] = enc(T_IN, 8'd0);
      pbuf[3] = enc(T_STA, 8'd1); pbuf[4] = enc(T_LDB, 8'd1); pbuf[5] = enc(T_LDA, 8'd0);
      pbuf[6] = enc(vecs[i].op, 8'd0); pbuf[7] = enc(T_OUT, 8'd1); pbuf[8] = enc(T_HLT, 8'd0);
      load_prog(9);
      in_vals[0] = vecs[i].a; in_vals[1] = vecs[i].b;
      run_prog(30);
      check($sformatf("v%0d_out", i), 32'(last_out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d_z", i), 32'(flag_z), 32'(vecs[i].exp_z));
      check($sformatf("v%0d_c", i), 32'(flag_c), 32'(vecs[i].exp_c));
      check($sformatf("v%0d_cyc", i), 32'(cyc), 32'd9);
      check($sformatf("v%0d_pid", i), 32'(last_pid), 32'd1);
    end

    // AND keeps the borrow left by SUB
    pbuf[0] = enc(T_IN, 8'd0);  pbuf[1] = enc(T_STA, 8'd0); pbuf[2] = enc(T_IN, 8'd0);
    pbuf[3] = enc(T_STA, 8'd1); pbuf[4] = enc(T_LDB, 8'd1); pbuf[5] = enc(T_LDA, 8'd0);
    pbuf[6] = enc(T_SUB, 8'd0); pbuf[7] = enc(T_AND, 8'd0); pbuf[8] = enc(T_OUT, 8'd1);
    pbuf[9] = enc(T_HLT, 8'd0);
    load_prog(10);
    in_vals[0] = 4'd2; in_vals[1] = 4'd5;
    run_prog(30);
    check("suband_out", 32'(last_out), 32'd5);
    check("suband_c", 32'(flag_c), 32'd1);
    check("suband_z", 32'(flag_z), 32'd0);

    // Stalled IN; a program write attempted while running must be ignored
    pbuf[0] = enc(T_IN, 8'd1); pbuf[1] = enc(T_OUT, 8'd4); pbuf[2] = enc(T_HLT, 8'd0);
    load_prog(3);
    port_ready = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    prog_we = 1'b1; prog_addr = 8'd1; prog_data = enc(T_HLT, 8'd0);
    rd_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (port_read) rd_cnt++;
      check($sformatf("stall_pc%0d", k), 32'(pc), 32'd0);
      @(negedge clock);
      prog_we = 1'b0;
    end
    if (port_read) rd_cnt++;
    check("stall_pid", 32'(port_id), 32'd1);
    port_ready = 1'b1; data_in = 4'd6;
    @(negedge clock);
    check("stall_rdcnt", 32'(rd_cnt), 32'd4);
    check("stall_pc_adv", 32'(pc), 32'd1);
    check("stall_rd_off", 32'(port_read), 32'd0);
    check("stall_wr", 32'(port_write), 32'd1);
    check("stall_dout", 32'(data_out), 32'd6);
    check("stall_wpid", 32'(port_id), 32'd4);
    @(negedge clock);
    check("halt_pid0", 32'(port_id), 32'd0);
    check("halt_wr0", 32'(port_write), 32'd0);
    @(negedge clock);
    check("stall_halted", 32'(halted), 32'd1);

    // Compare loop: equal values branch back, unequal values fall to HALT
    pbuf[0] = enc(T_IN, 8'd0);  pbuf[1] = enc(T_STA, 8'd0); pbuf[2] = enc(T_LDB, 8'd0);
    pbuf[3] = enc(T_IN, 8'd0);  pbuf[4] = enc(T_SUB, 8'd0); pbuf[5] = enc(T_JZ, 8'd0);
    pbuf[6] = enc(T_HLT, 8'd0);
    load_prog(7);
    in_vals[0] = 4'd7; in_vals[1] = 4'd7; in_vals[2] = 4'd3; in_vals[3] = 4'd4;
    run_prog(40);
    check("loop_eq_cyc", 32'(cyc), 32'd13);
    check("loop_eq_ins", 32'(in_idx), 32'd4);
    check("loop_eq_z", 32'(flag_z), 32'd0);
    check("loop_eq_pc", 32'(pc), 32'd6);
    in_vals[0] = 4'd3; in_vals[1] = 4'd4;
    run_prog(40);
    check("loop_ne_cyc", 32'(cyc), 32'd7);
    check("loop_ne_z", 32'(flag_z), 32'd0);
    check("loop_ne_err", 32'(error), 32'd0);

    // JC taken / not taken after SHL
    pbuf[0] = enc(T_IN, 8'd0);  pbuf[1] = enc(T_STA, 8'd0); pbuf[2] = enc(T_LDB, 8'd0);
    pbuf[3] = enc(T_SHL, 8'd0); pbuf[4] = enc(T_JC, 8'd6);  pbuf[5] = enc(T_HLT, 8'd0);
    pbuf[6] = enc(T_OUT, 8'd2); pbuf[7] = enc(T_HLT, 8'd0);
    load_prog(8);
    in_vals[0] = 4'd8;
    run_prog(30);
    check("jc_t_cyc", 32'(cyc), 32'd7);
    check("jc_t_out", 32'(last_out), 32'd8);
    check("jc_t_pc", 32'(pc), 32'd7);
    in_vals[0] = 4'd4;
    run_prog(30);
    check("jc_n_cyc", 32'(cyc), 32'd6);
    check("jc_n_outs", 32'(out_cnt), 32'd0);
    check("jc_n_pc", 32'(pc), 32'd5);

    // pc wraps from the last address to 0
    pbuf[0] = enc(T_JZ, 8'd3);  pbuf[1] = enc(T_JMP, 8'd14); pbuf[2] = enc(T_NOP, 8'd0);
    pbuf[3] = enc(T_HLT, 8'd0);
    load_prog(4);
    write_word(8'd14, enc(T_IN, 8'd0));
    write_word(8'd15, enc(T_AND, 8'd0));
    in_vals[0] = 4'd0;
    run_prog(30);
    check("wrap_cyc", 32'(cyc), 32'd6);
    check("wrap_pc", 32'(pc), 32'd3);
    check("wrap_z", 32'(flag_z), 32'd1);

    // Illegal opcode at address 2, then restart clears the error
    pbuf[0] = enc(T_NOP, 8'd0); pbuf[1] = enc(T_NOP, 8'd0); pbuf[2] = 12'hF00;
    pbuf[3] = enc(T_HLT, 8'd0);
    load_prog(4);
    run_prog(20);
    check("ill_cyc", 32'(cyc), 32'd3);
    check("ill_err", 32'(error), 32'd1);
    check("ill_pc", 32'(pc), 32'd2);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("ill_rs_err", 32'(error), 32'd0);
    check("ill_rs_busy", 32'(busy), 32'd1);
    check("ill_rs_pc", 32'(pc), 32'd0);
    for (int k = 0; k < 10 && !halted; k++) @(negedge clock);
    check("ill_rs_err2", 32'(error), 32'd1);
    check("ill_rs_pc2", 32'(pc), 32'd2);

    // Untaken out-of-range JZ is harmless; out-of-range GPR index faults
    pbuf[0] = enc(T_JZ, 8'h14); pbuf[1] = enc(T_LDA, 8'd4); pbuf[2] = enc(T_HLT, 8'd0);
    load_prog(3);
    run_prog(20);
    check("gpr_err", 32'(error), 32'd1);
    check("gpr_pc", 32'(pc), 32'd1);
    pbuf[0] = enc(T_JMP, 8'h10); pbuf[1] = enc(T_HLT, 8'd0);
    load_prog(2);
    run_prog(20);
    check("jmp_err", 32'(error), 32'd1);
    check("jmp_pc", 32'(pc), 32'd0);

    // Reset during a stalled OUT
    pbuf[0] = enc(T_OUT, 8'd5); pbuf[1] = enc(T_HLT, 8'd0);
    load_prog(2);
    port_ready = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("rout_wr", 32'(port_write), 32'd1);
    check("rout_pid", 32'(port_id), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("rout_wr_drop", 32'(port_write), 32'd0);
    check("rout_busy", 32'(busy), 32'd0);
    check("rout_dout", 32'(data_out), 32'd0);
    @(negedge clock); reset = 1'b1; port_ready = 1'b1;
    run_prog(20);
    check("rout_cyc", 32'(cyc), 32'd2);
    check("rout_pid2", 32'(last_pid), 32'd5);
    check("rout_out", 32'(last_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
